// File: rtl/multdiv_unit.sv
// Iterative signed WIDTH-bit multiply (radix-2 shift-add) / divide (restoring) feeding RF writeback.
// Latency: WIDTH+1 cycles from start to data_resultRDY; divide-by-zero completes in 1 cycle.
// Backpressure: none; starts arriving while busy are dropped, result pulse is never stalled.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_destReg,
    output logic             data_busy,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic [WIDTH-1:0] data_result,
    output logic             ctrl_writeEn_out,
    output logic [4:0]       ctrl_writeReg_out,
    output logic [WIDTH-1:0] data_writeReg_out
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH:0]         rem_q, rem_d;   // product high half / partial remainder
    logic [WIDTH-1:0]       quo_q, quo_d;   // multiplier (shifted out) / quotient (shifted in)
    logic [WIDTH:0]         dvs_q, dvs_d;   // multiplicand / divisor magnitude
    logic                   neg_q, neg_d;
    logic                   dz_q, dz_d;
    logic [4:0]             tag_q, tag_d;
    logic [WIDTH-1:0]       res_q, res_d;
    logic                   exc_q, exc_d;
    logic [4:0]             wreg_q, wreg_d;

    logic [WIDTH:0]         ext_b;
    logic [WIDTH:0]         mag_b;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH+1:0]       sum;
    logic [WIDTH:0]         shl;
    logic [WIDTH+1:0]       diff;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH-1:0]     prod_s;
    logic [WIDTH-1:0]       quo_s;
    logic                   mul_exc;
    logic                   div_exc;

    always_comb begin
        // -MIN_INT as a WIDTH-bit unsigned value is exactly 2^(WIDTH-1), so A needs no extra bit
        mag_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        ext_b   = {data_operandB[WIDTH-1], data_operandB};
        mag_b   = data_operandB[WIDTH-1] ? -ext_b : ext_b;

        sum     = {1'b0, rem_q} + {1'b0, (quo_q[0] ? dvs_q : '0)};
        shl     = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = {1'b0, shl} - {1'b0, dvs_q};

        prod    = {rem_q[WIDTH-1:0], quo_q};
        prod_s  = neg_q ? -prod : prod;
        mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        quo_s   = neg_q ? -quo_q : quo_q;
        // Only MIN_INT / -1 yields a positive quotient of 2^(WIDTH-1)
        div_exc = quo_q[WIDTH-1] & ~neg_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        tag_d   = tag_q;
        res_d   = res_q;
        exc_d   = exc_q;
        wreg_d  = wreg_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_MULT ^ ctrl_DIV) begin
                    state_d = ctrl_MULT ? S_MUL : S_DIV;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = mag_a;
                    dvs_d   = mag_b;
                    neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    dz_d    = (data_operandB == '0);
                    tag_d   = ctrl_destReg;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(WIDTH)) begin
                    res_d   = prod_s[WIDTH-1:0];
                    exc_d   = mul_exc;
                    wreg_d  = tag_q;
                    state_d = S_DONE;
                end else begin
                    rem_d = sum[WIDTH+1:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                if (dz_q) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    wreg_d  = tag_q;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(WIDTH)) begin
                    res_d   = quo_s;
                    exc_d   = div_exc;
                    wreg_d  = tag_q;
                    state_d = S_DONE;
                end else begin
                    if (!diff[WIDTH+1]) begin
                        rem_d = diff[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shl;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            wreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            wreg_q  <= wreg_d;
        end
    end

    assign data_busy         = (state_q == S_MUL) || (state_q == S_DIV);
    assign data_resultRDY    = (state_q == S_DONE);
    assign data_exception    = exc_q;
    assign data_result       = res_q;
    assign ctrl_writeReg_out = wreg_q;
    assign data_writeReg_out = res_q;
    assign ctrl_writeEn_out  = data_resultRDY & ~exc_q & (wreg_q != 5'd0);

endmodule
